// File: rtl/blake2_stream_ctrl.sv
// blake2_stream_ctrl: ping-pong block packer and init/next/final sequencer for a BLAKE2 core; `define BLAKE2_LEN_OVF_EN adds o_length_ovf
module blake2_stream_ctrl #(
   parameter int BUS_WIDTH   = 2,
   parameter int BLOCK_WIDTH = 8,
   parameter int DATA_LENGTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [BUS_WIDTH-1:0]   i_din,
   input  logic                   i_valid_in,
   output logic                   o_ready_out,
   input  logic                   i_new_hash_request,
   input  logic                   i_hash_ready,
   input  logic                   i_digest_valid,
   output logic                   o_init,
   output logic                   o_next,
   output logic                   o_final,
   output logic [BLOCK_WIDTH-1:0] o_block,
   output logic [DATA_LENGTH-1:0] o_data_length,
   output logic                   o_done
`ifdef BLAKE2_LEN_OVF_EN
   ,
   output logic                   o_length_ovf
`endif
);
   localparam int WORDS = BLOCK_WIDTH / BUS_WIDTH;
   localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
   typedef enum logic [2:0] {IDLE, INIT, GAP, WAIT_RDY, WAIT_DIG} state_t;
   state_t                 r_state;
   logic [BLOCK_WIDTH-1:0] r_buf [2];
   logic [DATA_LENGTH-1:0] r_blen [2];
   logic [1:0]             r_pend, r_last, r_first;
   logic                   r_wr, r_rd, r_req, r_any, r_first_blk, r_fin_sent;
   logic [IW-1:0]          r_idx;
   logic [DATA_LENGTH-1:0] r_cnt, r_dlen;
   logic [BLOCK_WIDTH-1:0] r_block;
   logic                   r_init, r_next, r_final, r_done;
   logic [DATA_LENGTH:0]   w_sum;
   logic                   w_issue, w_free, w_ready, w_acc, w_req, w_full, w_bnd, w_tag_prev, w_close, w_mark;
   logic [DATA_LENGTH-1:0] w_len;
   assign w_sum   = {1'b0, r_cnt} + (DATA_LENGTH+1)'(BUS_WIDTH);
   assign w_issue = r_state == WAIT_RDY && i_hash_ready && r_pend[r_rd];
   assign w_free  = !r_pend[r_wr] || (w_issue && r_rd == r_wr);
   // a held close blocks new words so they cannot leak into the closing message
   assign w_ready = w_free && !r_req;
   assign w_acc   = i_valid_in && w_ready;
   assign w_req   = i_new_hash_request || r_req;
   assign w_full  = w_acc && r_idx == IW'(WORDS-1);
   assign w_bnd   = !w_acc && r_idx == '0 && r_any;
   // a close on a block boundary retags the completed block if it has not been issued yet
   assign w_tag_prev = w_bnd && r_pend[~r_wr] && !(w_issue && r_rd != r_wr);
   assign w_close = w_req && (w_tag_prev || w_free);
   assign w_mark  = w_full || (w_close && !w_tag_prev);
   assign w_len   = w_acc ? w_sum[DATA_LENGTH-1:0] : r_cnt;
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_buf[0]    <= '0;
         r_buf[1]    <= '0;
         r_blen[0]   <= '0;
         r_blen[1]   <= '0;
         r_pend      <= '0;
         r_last      <= '0;
         r_first     <= '0;
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_req       <= 1'b0;
         r_any       <= 1'b0;
         r_first_blk <= 1'b1;
         r_fin_sent  <= 1'b0;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_dlen      <= '0;
         r_block     <= '0;
         r_init      <= 1'b0;
         r_next      <= 1'b0;
         r_final     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_init  <= 1'b0;
         r_next  <= 1'b0;
         r_final <= 1'b0;
         r_done  <= 1'b0;
         if (w_issue) begin
            r_pend[r_rd] <= 1'b0;
            r_buf[r_rd]  <= '0;
            r_rd         <= ~r_rd;
            r_block      <= r_buf[r_rd];
            r_dlen       <= r_blen[r_rd];
            r_next       <= !r_last[r_rd];
            r_final      <= r_last[r_rd];
            r_fin_sent   <= r_last[r_rd];
         end
         if (w_acc) begin
            r_buf[r_wr][r_idx*BUS_WIDTH +: BUS_WIDTH] <= i_din;
            r_cnt <= w_sum[DATA_LENGTH-1:0];
            r_any <= 1'b1;
            r_idx <= w_full ? '0 : r_idx + 1'b1;
         end
         if (w_close && w_tag_prev) r_last[~r_wr] <= 1'b1;
         if (w_mark) begin
            r_pend[r_wr]  <= 1'b1;
            r_last[r_wr]  <= w_close;
            r_blen[r_wr]  <= w_len;
            r_first[r_wr] <= r_first_blk;
            r_wr          <= ~r_wr;
            r_idx         <= '0;
         end
         if (w_close) begin
            r_cnt       <= '0;
            r_any       <= 1'b0;
            r_first_blk <= 1'b1;
         end else if (w_full) r_first_blk <= 1'b0;
         r_req <= w_req && !w_close;
         case (r_state)
            IDLE:     if (r_pend[r_rd]) r_state <= r_first[r_rd] ? INIT : WAIT_RDY;
            INIT:     if (i_hash_ready) begin
               r_init     <= 1'b1;
               r_fin_sent <= 1'b0;
               r_state    <= GAP;
            end
            GAP:      r_state <= r_fin_sent ? WAIT_DIG : WAIT_RDY;
            WAIT_RDY: if (w_issue) r_state <= GAP;
            WAIT_DIG: if (i_digest_valid) begin
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default:  r_state <= IDLE;
         endcase
      end
   end
`ifdef BLAKE2_LEN_OVF_EN
   logic       r_movf, r_ovf;
   logic [1:0] r_bovf;
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_movf <= 1'b0;
         r_ovf  <= 1'b0;
         r_bovf <= '0;
      end else begin
         if (w_acc && w_sum[DATA_LENGTH]) r_movf <= 1'b1;
         if (w_close) r_movf <= 1'b0;
         if (w_close && w_tag_prev) r_bovf[~r_wr] <= r_movf;
         if (w_mark) r_bovf[r_wr] <= r_movf || (w_acc && w_sum[DATA_LENGTH]);
         if (w_issue && r_last[r_rd] && r_bovf[r_rd]) r_ovf <= 1'b1;
         if (r_state == WAIT_DIG && i_digest_valid) r_ovf <= 1'b0;
      end
   end
   assign o_length_ovf = r_ovf;
`else
   logic w_unused_carry;
   assign w_unused_carry = w_sum[DATA_LENGTH];
`endif
   assign o_ready_out   = w_ready;
   assign o_init        = r_init;
   assign o_next        = r_next;
   assign o_final       = r_final;
   assign o_block       = r_block;
   assign o_data_length = r_dlen;
   assign o_done        = r_done;
endmodule

// File: tb/tb_blake2_stream_ctrl.sv
// tb_blake2_stream_ctrl: directed bench for blake2_stream_ctrl; define BLAKE2_LEN_OVF_EN to cover o_length_ovf
module tb_blake2_stream_ctrl;
   logic       clk = 1'b0;
   logic       reset, valid_in, nhr, hash_ready, digest_valid;
   logic [1:0] din;
   logic       ready_out, init, nxt, fin, done;
   logic [7:0] blk, dlen;
   int         checks = 0, errors = 0, n_init = 0;
   logic       q_fin [$];
   logic [7:0] q_blk [$];
   logic [7:0] q_len [$];
`ifdef BLAKE2_LEN_OVF_EN
   logic       length_ovf, ovf_at_fin = 1'b0;
`endif
   blake2_stream_ctrl dut (
      .i_clk(clk), .i_reset(reset), .i_din(din), .i_valid_in(valid_in), .o_ready_out(ready_out),
      .i_new_hash_request(nhr), .i_hash_ready(hash_ready), .i_digest_valid(digest_valid),
      .o_init(init), .o_next(nxt), .o_final(fin), .o_block(blk), .o_data_length(dlen), .o_done(done)
`ifdef BLAKE2_LEN_OVF_EN
      , .o_length_ovf(length_ovf)
`endif
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (init) n_init++;
      if (nxt || fin) begin
         q_fin.push_back(fin);
         q_blk.push_back(blk);
         q_len.push_back(dlen);
      end
`ifdef BLAKE2_LEN_OVF_EN
      if (fin) ovf_at_fin = length_ovf;
`endif
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic put(input logic [1:0] w, input logic s);
      bit ok = 1'b0;
      din = w;
      valid_in = 1'b1;
      for (int i = 0; i < 64 && !ok; i++) begin
         #1;
         if (ready_out) begin
            nhr = s;
            ok = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
      end
      valid_in = 1'b0;
      nhr = 1'b0;
      chk("put_accepted", 32'(ok), 1);
   endtask
   task automatic done_seq(input string tag);
      for (int i = 0; i < 400 && fin !== 1'b1; i++) @(negedge clk);
      chk({tag, "_final_seen"}, 32'(fin), 1);
      @(negedge clk);
      digest_valid = 1'b1;
      @(negedge clk);
      digest_valid = 1'b0;
      chk({tag, "_done"}, 32'(done), 1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 0);
   endtask
   task automatic chk_cmd(input string tag, input int k, input logic f, input logic [7:0] b, input logic [7:0] l);
      chk({tag, "_present"}, 32'(q_fin.size() > k), 1);
      if (q_fin.size() > k) begin
         chk({tag, "_kind"}, 32'(q_fin[k]), 32'(f));
         chk({tag, "_block"}, 32'(q_blk[k]), 32'(b));
         chk({tag, "_len"}, 32'(q_len[k]), 32'(l));
      end
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int base, ib, qsz;
      reset = 1'b1; din = '0; valid_in = 1'b0; nhr = 1'b0; hash_ready = 1'b1; digest_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready_out), 1);
      chk("rst_init", 32'(init), 0);
      chk("rst_next", 32'(nxt), 0);
      chk("rst_final", 32'(fin), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_block", 32'(blk), 0);
      chk("rst_len", 32'(dlen), 0);
      reset = 1'b0;
      @(negedge clk);
      // single full block closed by the strobe on its last word
      base = q_fin.size(); ib = n_init;
      put(2'd1, 1'b0); put(2'd2, 1'b0); put(2'd3, 1'b0); put(2'd0, 1'b1);
      @(negedge clk); chk("s1_init_early", 32'(init), 0);
      @(negedge clk); chk("s1_init", 32'(init), 1);
      repeat (2) @(negedge clk);
      chk("s1_final", 32'(fin), 1);
      chk("s1_next", 32'(nxt), 0);
      chk("s1_block", 32'(blk), 32'h39);
      chk("s1_len", 32'(dlen), 8);
      done_seq("s1");
      chk("s1_block_hold", 32'(blk), 32'h39);
      chk("s1_ncmd", 32'(q_fin.size() - base), 1);
      chk("s1_ninit", 32'(n_init - ib), 1);
      // one full block plus a zero-padded partial block
      base = q_fin.size(); ib = n_init;
      put(2'd1, 1'b0); put(2'd2, 1'b0); put(2'd3, 1'b0); put(2'd0, 1'b0); put(2'd1, 1'b0); put(2'd2, 1'b1);
      done_seq("s2");
      chk_cmd("s2_c0", base, 1'b0, 8'h39, 8'd8);
      chk_cmd("s2_c1", base + 1, 1'b1, 8'h09, 8'd12);
      chk("s2_ncmd", 32'(q_fin.size() - base), 2);
      chk("s2_ninit", 32'(n_init - ib), 1);
      // empty message
      base = q_fin.size(); ib = n_init;
      nhr = 1'b1;
      @(negedge clk);
      nhr = 1'b0;
      done_seq("s3");
      chk_cmd("s3_c0", base, 1'b1, 8'h00, 8'd0);
      chk("s3_ninit", 32'(n_init - ib), 1);
      // backpressure: both buffers fill while the core is busy
      base = q_fin.size(); ib = n_init;
      hash_ready = 1'b0;
      put(2'd1, 1'b0); put(2'd2, 1'b0); put(2'd3, 1'b0); put(2'd0, 1'b0);
      #1 chk("s4_ready_one_full", 32'(ready_out), 1);
      put(2'd3, 1'b0); put(2'd3, 1'b0); put(2'd0, 1'b0); put(2'd1, 1'b0);
      #1 chk("s4_ready_low", 32'(ready_out), 0);
      repeat (5) @(negedge clk);
      chk("s4_no_init", 32'(n_init - ib), 0);
      chk("s4_ready_still_low", 32'(ready_out), 0);
      hash_ready = 1'b1;
      put(2'd2, 1'b0); put(2'd0, 1'b0); put(2'd1, 1'b0); put(2'd3, 1'b1);
      done_seq("s4");
      chk_cmd("s4_c0", base, 1'b0, 8'h39, 8'd8);
      chk_cmd("s4_c1", base + 1, 1'b0, 8'h4F, 8'd16);
      chk_cmd("s4_c2", base + 2, 1'b1, 8'hD2, 8'd24);
      chk("s4_ninit", 32'(n_init - ib), 1);
      #1 chk("s4_ready_back", 32'(ready_out), 1);
      // reset one cycle after init discards the pending block
      put(2'd1, 1'b0); put(2'd2, 1'b0); put(2'd3, 1'b0); put(2'd0, 1'b1);
      for (int i = 0; i < 50 && init !== 1'b1; i++) @(negedge clk);
      chk("s5_init_seen", 32'(init), 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      qsz = q_fin.size(); ib = n_init;
      #1;
      chk("s5_init", 32'(init), 0);
      chk("s5_next", 32'(nxt), 0);
      chk("s5_final", 32'(fin), 0);
      chk("s5_done", 32'(done), 0);
      chk("s5_block", 32'(blk), 0);
      chk("s5_len", 32'(dlen), 0);
      chk("s5_ready", 32'(ready_out), 1);
      repeat (6) @(negedge clk);
      chk("s5_no_cmd", 32'(q_fin.size() - qsz), 0);
      chk("s5_no_init", 32'(n_init - ib), 0);
      base = q_fin.size();
      put(2'd1, 1'b0); put(2'd2, 1'b0); put(2'd3, 1'b0); put(2'd0, 1'b1);
      done_seq("s5b");
      chk_cmd("s5b_c0", base, 1'b1, 8'h39, 8'd8);
      chk("s5b_ninit", 32'(n_init - ib), 1);
`ifdef BLAKE2_LEN_OVF_EN
      // 132 words = 264 bits wraps the 8-bit length counter to 8
      base = q_fin.size();
      for (int i = 0; i < 132; i++) put(2'(i % 4), i == 131);
      done_seq("s6");
      chk_cmd("s6_c0", base, 1'b0, 8'hE4, 8'd8);
      chk_cmd("s6_c31", base + 31, 1'b0, 8'hE4, 8'd0);
      chk_cmd("s6_c32", base + 32, 1'b1, 8'hE4, 8'd8);
      chk("s6_ovf_at_final", 32'(ovf_at_fin), 1);
      chk("s6_ovf_cleared", 32'(length_ovf), 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
